// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the IO-bus UART blocks.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

   localparam int TXDATA_OFS = 0;
   localparam int STATUS_OFS = 4;

   localparam int FULL_B  = 0;
   localparam int EMPTY_B = 1;
   localparam int BUSY_B  = 2;
   localparam int OVR_B   = 3;
   localparam int CNT_LSB = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with occupancy count; a push is accepted when full
// only if a pop happens in the same cycle.
module uart_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IO bus: TXDATA store pushes
// a byte into the FIFO, STATUS reads/clears the sticky overrun flag.
import uart_pkg::*;

module iobus_uart_tx #(
   parameter int          CLK_HZ    = 50_000_000,
   parameter int          BAUD      = 115200,
   parameter int          DEPTH     = 8,
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IO_RD_DATA,
   output logic        TXD
);

   localparam int DIVISOR = CLK_HZ / BAUD;
   localparam int BW      = $clog2(DIVISOR);
   localparam int CW      = $clog2(DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
   localparam logic [31:0]   TX_ADDR   = BASE_ADDR + 32'(TXDATA_OFS);
   localparam logic [31:0]   ST_ADDR   = BASE_ADDR + 32'(STATUS_OFS);

   uart_tx_state_t state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           ovr_q, ovr_d;
   logic           txd_q, txd_d;
   logic           wr_tx, wr_st, pop, full, empty, busy, baud_tick;
   logic [7:0]     fifo_rdata;
   logic [CW-1:0]  count;
   logic [31:0]    status;
   logic           unused_data;

   assign unused_data = ^IOBUS_OUT[31:8];
   assign wr_tx       = IOBUS_WR && (IOBUS_ADDR == TX_ADDR);
   assign wr_st       = IOBUS_WR && (IOBUS_ADDR == ST_ADDR);
   assign pop         = (state_q == IDLE) && !empty;
   assign baud_tick   = (baud_q == BAUD_LAST);

   uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (wr_tx),
      .wdata_i (IOBUS_OUT[7:0]),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         ovr_q   <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         ovr_q   <= ovr_d;
         txd_q   <= txd_d;
      end
   end

   always_ff @(posedge CLK) begin
      shift_q <= shift_d;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d = START;
               baud_d  = '0;
               shift_d = fifo_rdata;
            end
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_tick) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_tick) begin
               state_d = IDLE;
               baud_d  = '0;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // TXD is registered from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      busy = (state_q != IDLE);
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_comb begin
      ovr_d = ovr_q;
      if (wr_st)                      ovr_d = 1'b0;
      else if (wr_tx && full && !pop) ovr_d = 1'b1;
   end

   always_comb begin
      status                  = '0;
      status[FULL_B]          = full;
      status[EMPTY_B]         = empty;
      status[BUSY_B]          = busy;
      status[OVR_B]           = ovr_q;
      status[CNT_LSB +: 4]    = 4'(count);
   end

   assign IO_RD_DATA = (IOBUS_ADDR == ST_ADDR) ? status : 32'h0;
   assign TXD        = txd_q;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench: a frame-timeline model (byte queue + frame start edge)
// predicts TXD and STATUS every cycle, plus hand-computed literal checks.
module tb_iobus_uart_tx;

   localparam int CLK_HZ = 1000;
   localparam int BAUD   = 100;
   localparam int DIV    = CLK_HZ / BAUD;
   localparam int DEPTH  = 8;
   localparam logic [31:0] TX_A    = 32'h1100_0100;
   localparam logic [31:0] ST_A    = 32'h1100_0104;
   localparam logic [31:0] OTHER_A = 32'h1100_0108;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] IOBUS_ADDR = 32'h0;
   logic [31:0] IOBUS_OUT = 32'h0;
   logic [31:0] IO_RD_DATA;
   logic        TXD;

   int n_chk  = 0;
   int n_pass = 0;
   bit check_en = 1'b0;

   logic [7:0] q[$];
   bit         m_ovr = 1'b0;
   bit         in_frame = 1'b0;
   bit         m_full, m_pop;
   int         n_edge = 0;
   int         t0 = 0;
   logic [7:0] fbyte = 8'h0;

   logic a5_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   iobus_uart_tx #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .DEPTH     (DEPTH),
      .BASE_ADDR (TX_A)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .IO_RD_DATA (IO_RD_DATA),
      .TXD        (TXD)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Line level from the frame timeline: start bit, 8 data bits LSB first, stop bit.
   function automatic logic exp_txd();
      int pos;
      if (!in_frame) return 1'b1;
      pos = (n_edge - t0) / DIV;
      if (pos == 0) return 1'b0;
      if (pos <= 8) return fbyte[pos-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [3:0] c;
      c = 4'(q.size());
      return {24'b0, c, m_ovr, in_frame, q.size() == 0, q.size() == DEPTH};
   endfunction

   initial forever begin
      @(posedge CLK);
      n_edge++;
      if (RST) begin
         q.delete();
         m_ovr    = 1'b0;
         in_frame = 1'b0;
      end else begin
         m_full = (q.size() == DEPTH);
         m_pop  = !in_frame && (q.size() != 0);
         if (in_frame && (n_edge - t0 == 10 * DIV)) in_frame = 1'b0;
         if (m_pop) begin
            fbyte    = q.pop_front();
            t0       = n_edge;
            in_frame = 1'b1;
         end
         if (IOBUS_WR && IOBUS_ADDR == TX_A) begin
            if (!m_full || m_pop) q.push_back(IOBUS_OUT[7:0]);
            else                  m_ovr = 1'b1;
         end
         if (IOBUS_WR && IOBUS_ADDR == ST_A) m_ovr = 1'b0;
      end
   end

   initial forever begin
      @(negedge CLK);
      if (check_en) begin
         chk("txd", {31'b0, TXD}, {31'b0, exp_txd()});
         chk("rd_data", IO_RD_DATA, (IOBUS_ADDR == ST_A) ? exp_status() : 32'h0);
      end
   end

   task automatic cyc(input logic wr, input logic [31:0] a, input logic [31:0] d);
      IOBUS_WR   = wr;
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      @(posedge CLK);
      #2;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, ST_A, 32'h0);
   endtask

   task automatic peek_status(input string name, input logic [31:0] exp);
      IOBUS_WR   = 1'b0;
      IOBUS_ADDR = ST_A;
      #1;
      chk(name, IO_RD_DATA, exp);
   endtask

   initial begin
      logic [31:0] r;
      int          sel;

      RST = 1'b1;
      cyc(1'b0, ST_A, 32'h0);
      check_en = 1'b1;
      cyc(1'b0, ST_A, 32'h0);
      cyc(1'b0, ST_A, 32'h0);
      chk("rst_status", IO_RD_DATA, 32'h2);
      chk("rst_txd", {31'b0, TXD}, 32'h1);
      RST = 1'b0;
      idle(3);

      // Single byte 0xA5 with junk in the upper bits.
      cyc(1'b1, TX_A, 32'hFFFF_FFA5);
      cyc(1'b0, ST_A, 32'h0);
      chk("a5_start", {31'b0, TXD}, 32'h0);
      for (int m = 1; m <= 101; m++) begin
         cyc(1'b0, ST_A, 32'h0);
         if (m % 10 == 5) chk("a5_bit", {31'b0, TXD}, {31'b0, a5_bits[m/10]});
         if (m == 99)  chk("a5_busy", IO_RD_DATA, 32'h6);
         if (m == 100) chk("a5_done", IO_RD_DATA, 32'h2);
      end

      // Back-to-back 0x01 then 0x80.
      cyc(1'b1, TX_A, 32'h01);
      cyc(1'b1, TX_A, 32'h80);
      chk("b2b_start", {31'b0, TXD}, 32'h0);
      for (int m = 1; m <= 202; m++) begin
         cyc(1'b0, ST_A, 32'h0);
         if (m == 15)  chk("b2b_lsb1", {31'b0, TXD}, 32'h1);
         if (m == 50)  chk("b2b_mid_cnt", IO_RD_DATA, 32'h14);
         if (m == 100) begin
            chk("b2b_gap_txd", {31'b0, TXD}, 32'h1);
            chk("b2b_gap_status", IO_RD_DATA, 32'h10);
         end
         if (m == 101) chk("b2b_second_start", {31'b0, TXD}, 32'h0);
         if (m == 176) chk("b2b_bit6", {31'b0, TXD}, 32'h0);
         if (m == 186) chk("b2b_msb", {31'b0, TXD}, 32'h1);
         if (m == 202) chk("b2b_done", IO_RD_DATA, 32'h2);
      end

      // Overflow: ten pushes during one frame.
      for (int i = 0; i < 10; i++) begin
         r = $urandom();
         cyc(1'b1, TX_A, {r[31:8], 8'(8'h30 + i)});
      end
      peek_status("ovf_status", 32'h8D);
      IOBUS_ADDR = TX_A;
      #1;
      chk("txdata_reads_zero", IO_RD_DATA, 32'h0);
      cyc(1'b1, ST_A, 32'hFFFF_FFFF);
      chk("ovf_cleared", IO_RD_DATA, 32'h85);
      idle(950);
      chk("ovf_drained", IO_RD_DATA, 32'h2);

      // Full FIFO with a push landing on the pop cycle.
      for (int i = 0; i < 9; i++) cyc(1'b1, TX_A, $urandom());
      peek_status("fill8", 32'h85);
      idle(93);
      chk("full_idle", IO_RD_DATA, 32'h81);
      cyc(1'b1, TX_A, $urandom());
      peek_status("full_push_pop", 32'h85);

      // Reset in the middle of data bit 3.
      idle(45);
      RST = 1'b1;
      cyc(1'b0, ST_A, 32'h0);
      chk("midrst_txd", {31'b0, TXD}, 32'h1);
      chk("midrst_status", IO_RD_DATA, 32'h2);
      RST = 1'b0;
      idle(300);
      chk("post_rst_txd", {31'b0, TXD}, 32'h1);
      chk("post_rst_status", IO_RD_DATA, 32'h2);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         sel = $urandom_range(0, 99);
         r   = $urandom();
         if (sel < 6)       cyc(1'b1, TX_A, r);
         else if (sel < 8)  cyc(1'b1, ST_A, r);
         else if (sel < 10) cyc(1'b1, r[0] ? OTHER_A : TX_A + 32'h1, r);
         else if (sel < 13) cyc(1'b0, TX_A, r);
         else               cyc(1'b0, ST_A, r);
      end
      idle(900);
      chk("rand_drained_txd", {31'b0, TXD}, 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
